// File: rtl/pcap_dma_sched.sv
// pcap_dma_sched: drains the capture FIFO into host buffer blocks as DMA bursts,
// double-buffers the host block address and reports each block handover by irq.
module pcap_dma_sched #(
  parameter int BURST_LEN = 16
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        pcap_armed_i,
  input  logic [10:0] fifo_count_i,
  output logic        dma_req_o,
  input  logic        dma_ack_i,
  input  logic        dma_done_i,
  output logic [31:0] dma_addr_o,
  output logic [7:0]  dma_len_o,
  input  logic [31:0] DMA_ADDR,
  input  logic        DMA_ADDR_WSTB,
  input  logic [31:0] BLOCK_SIZE,
  input  logic [31:0] TIMEOUT,
  output logic        irq_o,
  output logic [3:0]  irq_status_o,
  output logic [23:0] irq_words_o,
  output logic        dma_abort_o
);

  typedef enum logic [2:0] {IDLE, WAIT, REQ, BUSY, FINISH} state_t;

  localparam logic [7:0]  BURST   = 8'(BURST_LEN);
  localparam logic [30:0] BURST_W = 31'(BURST_LEN);

  state_t      state, state_n;
  logic        armed_d, next_valid, addr_err, tflag;
  logic [31:0] next_addr, cur_addr, timer;
  logic [30:0] words, blk_words;
  logic [7:0]  len;

  logic        armed_rise, partial, timed_out, block_full;
  logic [30:0] remaining, words_sum, blk_size_words;
  logic [7:0]  need;
  logic [10:0] need_ext;
  logic        unused_size_bits;

  logic        start, swap, accum, len_load, tflag_set, irq_clr, irq_set, abort_set;
  logic [7:0]  len_n;
  logic [3:0]  irq_status_n;
  logic [23:0] irq_words_n;

  assign unused_size_bits = ^BLOCK_SIZE[1:0];
  assign armed_rise       = pcap_armed_i & ~armed_d;
  // A zero block size stands for the largest block, 2^30 words.
  assign blk_size_words   = (BLOCK_SIZE[31:2] == 30'd0) ? 31'h4000_0000 : {1'b0, BLOCK_SIZE[31:2]};
  assign remaining        = blk_words - words;
  assign need             = (remaining >= BURST_W) ? BURST : remaining[7:0];
  assign need_ext         = {3'b000, need};
  assign partial          = (fifo_count_i != 11'd0) && (fifo_count_i < need_ext);
  assign timed_out        = partial && (TIMEOUT != 32'd0) && (timer == TIMEOUT);
  assign words_sum        = words + {23'd0, len};
  assign block_full       = (words_sum == blk_words);

  assign dma_req_o  = (state == REQ);
  assign dma_addr_o = cur_addr;
  assign dma_len_o  = len;

  always_ff @(posedge clk_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n      = state;
    start        = 1'b0;
    swap         = 1'b0;
    accum        = 1'b0;
    len_load     = 1'b0;
    len_n        = len;
    tflag_set    = 1'b0;
    irq_clr      = 1'b0;
    irq_set      = 1'b0;
    abort_set    = 1'b0;
    irq_status_n = 4'b0000;
    irq_words_n  = words[23:0];
    case (state)
      IDLE: begin
        if (armed_rise) begin
          if (next_valid) begin
            start   = 1'b1;
            state_n = WAIT;
          end else begin
            irq_set      = 1'b1;
            abort_set    = 1'b1;
            irq_clr      = 1'b1;
            irq_status_n = 4'b1000;
            irq_words_n  = 24'd0;
          end
        end
      end
      WAIT: begin
        if (!pcap_armed_i) begin
          if (fifo_count_i != 11'd0) begin
            len_load = 1'b1;
            len_n    = (fifo_count_i < need_ext) ? fifo_count_i[7:0] : need;
            state_n  = REQ;
          end else begin
            state_n = FINISH;
          end
        end else if (fifo_count_i >= need_ext) begin
          len_load = 1'b1;
          len_n    = need;
          state_n  = REQ;
        end else if (timed_out) begin
          len_load  = 1'b1;
          len_n     = fifo_count_i[7:0];
          tflag_set = 1'b1;
          state_n   = REQ;
        end
      end
      REQ: begin
        if (dma_ack_i) state_n = BUSY;
      end
      BUSY: begin
        if (dma_done_i) begin
          accum   = 1'b1;
          state_n = WAIT;
          if (block_full || tflag) begin
            irq_set      = 1'b1;
            irq_clr      = 1'b1;
            irq_status_n = {addr_err, tflag, 1'b0, block_full};
            irq_words_n  = words_sum[23:0];
            // With no follow-on buffer the capture has overrun the host.
            if (next_valid) begin
              swap = 1'b1;
            end else begin
              irq_status_n[3] = 1'b1;
              abort_set       = 1'b1;
              state_n         = IDLE;
            end
          end
        end
      end
      FINISH: begin
        irq_set      = 1'b1;
        irq_clr      = 1'b1;
        irq_status_n = {addr_err, 1'b0, 1'b1, 1'b0};
        state_n      = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      armed_d      <= pcap_armed_i;
      next_valid   <= 1'b0;
      next_addr    <= 32'd0;
      addr_err     <= 1'b0;
      tflag        <= 1'b0;
      timer        <= 32'd0;
      cur_addr     <= 32'd0;
      words        <= 31'd0;
      blk_words    <= 31'd0;
      len          <= 8'd0;
      irq_o        <= 1'b0;
      irq_status_o <= 4'b0000;
      irq_words_o  <= 24'd0;
      dma_abort_o  <= 1'b0;
    end else begin
      armed_d     <= pcap_armed_i;
      irq_o       <= irq_set;
      dma_abort_o <= abort_set;
      if (irq_set) begin
        irq_status_o <= irq_status_n;
        irq_words_o  <= irq_words_n;
      end
      if (start || swap) next_valid <= 1'b0;
      if (DMA_ADDR_WSTB && !next_valid) begin
        next_addr  <= DMA_ADDR;
        next_valid <= 1'b1;
      end
      addr_err <= (addr_err & ~irq_clr) | (DMA_ADDR_WSTB & next_valid);
      if (irq_clr)        tflag <= 1'b0;
      else if (tflag_set) tflag <= 1'b1;
      if (state == WAIT && state_n == WAIT) begin
        if (partial) timer <= timer + 32'd1;
      end else begin
        timer <= 32'd0;
      end
      if (start || swap) begin
        cur_addr <= next_addr;
        words    <= 31'd0;
      end else if (accum) begin
        cur_addr <= cur_addr + {22'd0, len, 2'b00};
        words    <= words_sum;
      end
      if (start)    blk_words <= blk_size_words;
      if (len_load) len       <= len_n;
    end
  end

endmodule
